// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - drives the RSA control core through inversion and mod-exp phases per job
// Caches the last inverted key so repeat p/q jobs go straight to mod-exp.
module rsa_job_sequencer #(
  parameter int WIDTH          = 128,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 17
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_p,
  input  logic [WIDTH-1:0]     req_q,
  input  logic                 req_encrypt_decrypt,
  input  logic [2*WIDTH-1:0]   req_msg,
  output logic [WIDTH-1:0]     core_p,
  output logic [WIDTH-1:0]     core_q,
  output logic                 core_encrypt_decrypt,
  output logic [2*WIDTH-1:0]   core_msg_in,
  output logic                 core_reset_inverter,
  output logic                 core_reset_mod_exp,
  input  logic                 core_inverter_finish,
  input  logic                 core_mod_exp_finish,
  input  logic [2*WIDTH-1:0]   core_msg_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2*WIDTH-1:0]   resp_data,
  output logic                 resp_error,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_INV_PULSE, S_INV_GUARD, S_INV_WAIT,
    S_EXP_PULSE, S_EXP_GUARD, S_EXP_WAIT, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 key_valid_q, key_valid_d;
  logic [WIDTH-1:0]     last_p_q, last_p_d, last_q_q, last_q_d;
  logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
  logic                 enc_q, enc_d;
  logic [2*WIDTH-1:0]   msg_q, msg_d, data_q, data_d;
  logic                 err_q, err_d;
  logic                 key_hit, timed_out;

  assign req_ready            = reset_n && (state_q == S_IDLE);
  assign busy                 = (state_q != S_IDLE);
  assign resp_valid           = (state_q == S_DONE);
  assign core_reset_inverter  = (state_q == S_INV_PULSE);
  assign core_reset_mod_exp   = (state_q == S_EXP_PULSE);
  assign core_p               = p_q;
  assign core_q               = q_q;
  assign core_encrypt_decrypt = enc_q;
  assign core_msg_in          = msg_q;
  assign resp_data            = data_q;
  assign resp_error           = err_q;

  assign key_hit   = key_valid_q && (req_p == last_p_q) && (req_q == last_q_q);
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    last_p_d    = last_p_q;
    last_q_d    = last_q_q;
    p_d         = p_q;
    q_d         = q_q;
    enc_d       = enc_q;
    msg_d       = msg_q;
    data_d      = data_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          p_d   = req_p;
          q_d   = req_q;
          enc_d = req_encrypt_decrypt;
          msg_d = req_msg;
          if (key_hit) begin
            state_d = S_EXP_PULSE;
          end else begin
            key_valid_d = 1'b0;
            state_d     = S_INV_PULSE;
          end
        end
      end
      S_INV_PULSE: begin
        cnt_d   = '0;
        state_d = S_INV_GUARD;
      end
      // A finish flag left high by the previous job must not count here.
      S_INV_GUARD: state_d = S_INV_WAIT;
      S_INV_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (core_inverter_finish) begin
          last_p_d    = p_q;
          last_q_d    = q_q;
          key_valid_d = 1'b1;
          state_d     = S_EXP_PULSE;
        end else if (timed_out) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EXP_PULSE: begin
        cnt_d   = '0;
        state_d = S_EXP_GUARD;
      end
      S_EXP_GUARD: state_d = S_EXP_WAIT;
      S_EXP_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (core_mod_exp_finish) begin
          data_d  = core_msg_out;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timed_out) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      last_p_q    <= '0;
      last_q_q    <= '0;
      p_q         <= '0;
      q_q         <= '0;
      enc_q       <= 1'b0;
      msg_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      last_p_q    <= last_p_d;
      last_q_q    <= last_q_d;
      p_q         <= p_d;
      q_q         <= q_d;
      enc_q       <= enc_d;
      msg_q       <= msg_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

endmodule
